morse_guess_buffer: RTL and testbench
=====================================

// Module: morse_guess_buffer
// PURPOSE
//   Parametrised player-2 guess accumulator for the morse guessing game.
//   - Packs decoded dot/line pulses into a right-aligned bit string: dot = 2'b10, line = 4'b1110.
//   - Supports backspace and bounds the entry by width and symbol count.
//   - Runs a finish/check/result handshake that scores the entry against player 1's value.
//   - Sits between input_module (ld_dot/ld_line pulses) and the game controller/display.
// PARAMETERS
//   WIDTH        20  bit width of packed guess and target
//   MAX_SYMBOLS  8   maximum symbols held; sizes the backspace history stack
//   CNT_W        5   width of bit_len/sym_count; must be >= clog2(max(WIDTH,MAX_SYMBOLS)+1)
// PORTS
//   clock         in   1        single system clock, all logic on posedge
//   reset         in   1        synchronous, active-high reset
//   ld_dot        in   1        one-cycle pulse: append dot
//   ld_line       in   1        one-cycle pulse: append line
//   backspace     in   1        one-cycle pulse: remove most recent symbol
//   finish        in   1        one-cycle pulse: submit guess for scoring
//   clear         in   1        one-cycle pulse: discard guess/result, return to ENTRY
//   target        in   WIDTH    player 1 packed value; sampled in CHECK
//   q             out  WIDTH    packed guess, newest symbol in LSBs
//   bit_len       out  CNT_W    number of valid bits in q
//   sym_count     out  CNT_W    number of symbols held
//   overflow      out  1        sticky: a symbol was rejected for lack of room
//   busy          out  1        high in CHECK
//   result_valid  out  1        high in DONE
//   correct       out  1        valid only while result_valid; 0 otherwise
// BEHAVIOUR
//   Reset: all outputs 0, history stack 0, state = ENTRY. Reset overrides every other input.
//   States and transitions:
//     ENTRY -> CHECK  on finish.
//     CHECK -> DONE   unconditionally after 1 cycle.
//     DONE  -> ENTRY  on clear; otherwise holds.
//   clear in ENTRY or CHECK: zeroes q, bit_len, sym_count, overflow and the stack; state = ENTRY.
//   ENTRY input priority (one action per cycle): clear > finish > backspace > ld_dot/ld_line.
//   Append:
//     - Dot:  q <= {q[WIDTH-3:0],2'b10};   bit_len += 2; sym_count += 1.
//     - Line: q <= {q[WIDTH-5:0],4'b1110}; bit_len += 4; sym_count += 1.
//     - Symbol type (0 = dot, 1 = line) is pushed onto the history stack.
//   Room check: the append is rejected if bit_len + symlen > WIDTH or sym_count == MAX_SYMBOLS.
//     On rejection: q, bit_len, sym_count and the stack are unchanged; overflow <= 1.
//   ld_dot and ld_line high in the same cycle: both ignored, no flag change.
//   Backspace:
//     - Pops the stack; q >>= 2 (dot) or 4 (line), zero-filled at the MSB end.
//     - bit_len and sym_count are decremented accordingly.
//     - overflow is NOT cleared.
//     - Backspace with sym_count == 0 is a no-op.
//   Latency: an input pulse in cycle n is reflected on q/bit_len/sym_count in cycle n+1.
//   Scoring:
//     - finish in cycle n -> busy = 1 in cycle n+1 (CHECK).
//     - In CHECK: correct_reg <= (q == target) && !overflow && (sym_count != 0).
//     - result_valid = 1 from cycle n+2 (DONE) until clear or reset.
//   In CHECK and DONE, ld_dot, ld_line, backspace and finish are ignored; q is frozen.
//   finish with an empty guess: the sequence runs normally and correct = 0.
//   A target change while in DONE does not alter correct.
// TESTING
//   1. Defaults. reset, then dot, line, finish with target=20'h0002E
//      -> q=0x2E, bit_len=6, sym_count=2; busy 1 cycle; result_valid=1 and correct=1 two cycles after finish.
//   2. dot, line, backspace -> q=0x2, bit_len=2, sym_count=1.
//      A second and third backspace -> q=0, counts 0, no underflow.
//   3. Five lines -> q=0xEEEEE, bit_len=20.
//      A following dot -> q unchanged, overflow=1.
//      finish with target=0xEEEEE -> correct=0.
//   4. ld_dot and ld_line in the same cycle -> no change to q/counts/overflow.
//      In DONE, a dot pulse -> q unchanged.
//      clear -> ENTRY with q=0, result_valid=0.
//   5. Reset asserted during CHECK -> next cycle all outputs 0, state ENTRY.
//      A subsequent dot -> q=0x2.
//   6. MAX_SYMBOLS=3, WIDTH=20: four dots -> q=0x2A, sym_count=3, overflow=1.

Source files
------------

// File: rtl/morse_guess_buffer.sv
// morse_guess_buffer: player-2 guess accumulator for the morse guessing game.
// Packs dot (2'b10) and line (4'b1110) symbols into a right-aligned bit string,
// supports backspace through a one-bit-per-symbol history stack, and scores the
// finished entry against player 1's packed target.
module morse_guess_buffer #(
    parameter int WIDTH       = 20,
    parameter int MAX_SYMBOLS = 8,
    parameter int CNT_W       = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ld_dot,
    input  logic             ld_line,
    input  logic             backspace,
    input  logic             finish,
    input  logic             clear,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] bit_len,
    output logic [CNT_W-1:0] sym_count,
    output logic             overflow,
    output logic             busy,
    output logic             result_valid,
    output logic             correct
);

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] q_reg;
    logic [CNT_W-1:0] bit_len_reg;
    logic [CNT_W-1:0] sym_count_reg;
    logic             overflow_reg;
    logic             busy_reg;
    logic             result_valid_reg;
    logic             correct_reg;

    // History stack: bit i holds the type of symbol i (0 = dot, 1 = line),
    // symbol 0 being the oldest. Slots above sym_count are kept at zero.
    logic [MAX_SYMBOLS-1:0] stack_reg;
    logic [MAX_SYMBOLS-1:0] stack_next;
    logic [MAX_SYMBOLS-1:0] top_sel;

    logic             in_entry;
    logic             do_pop;
    logic             want_push;
    logic             do_push;
    logic             push_line;
    logic             top_is_line;
    logic             room_ok;
    logic [CNT_W:0]   sym_len;
    logic [CNT_W:0]   bit_len_sum;

    // Decode the single ENTRY action for this cycle: clear > finish > backspace > append.
    always_comb begin
        in_entry    = (state_reg == ST_ENTRY);
        do_pop      = in_entry && !clear && !finish && backspace && (sym_count_reg != '0);
        want_push   = in_entry && !clear && !finish && !backspace && (ld_dot ^ ld_line);
        push_line   = ld_line;
        sym_len     = push_line ? (CNT_W+1)'(4) : (CNT_W+1)'(2);
        bit_len_sum = {1'b0, bit_len_reg} + sym_len;
        room_ok     = (bit_len_sum <= (CNT_W+1)'(WIDTH)) &&
                      (sym_count_reg != CNT_W'(MAX_SYMBOLS));
        do_push     = want_push && room_ok;
        top_is_line = |top_sel;
    end

    // Per-slot stack update: push writes the slot at sym_count, pop zeroes the top slot.
    generate
        for (genvar gi = 0; gi < MAX_SYMBOLS; gi++) begin : g_stack
            assign top_sel[gi]    = stack_reg[gi] && (sym_count_reg == CNT_W'(gi + 1));
            assign stack_next[gi] = clear                                        ? 1'b0 :
                                    (do_push && sym_count_reg == CNT_W'(gi))     ? push_line :
                                    (do_pop  && sym_count_reg == CNT_W'(gi + 1)) ? 1'b0 :
                                    stack_reg[gi];
        end
    endgenerate

    // Stack register.
    always_ff @(posedge clock) begin
        if (reset) begin
            stack_reg <= '0;
        end else begin
            stack_reg <= stack_next;
        end
    end

    // Entry / check / done sequencing with the guess datapath and scoring.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= ST_ENTRY;
            q_reg            <= '0;
            bit_len_reg      <= '0;
            sym_count_reg    <= '0;
            overflow_reg     <= 1'b0;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b0;
            correct_reg      <= 1'b0;
        end else if (clear) begin
            state_reg        <= ST_ENTRY;
            q_reg            <= '0;
            bit_len_reg      <= '0;
            sym_count_reg    <= '0;
            overflow_reg     <= 1'b0;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b0;
            correct_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_ENTRY: begin
                    if (finish) begin
                        state_reg <= ST_CHECK;
                        busy_reg  <= 1'b1;
                    end else if (do_pop) begin
                        if (top_is_line) begin
                            q_reg       <= q_reg >> 4;
                            bit_len_reg <= bit_len_reg - CNT_W'(4);
                        end else begin
                            q_reg       <= q_reg >> 2;
                            bit_len_reg <= bit_len_reg - CNT_W'(2);
                        end
                        sym_count_reg <= sym_count_reg - CNT_W'(1);
                    end else if (do_push) begin
                        if (push_line) begin
                            q_reg <= {q_reg[WIDTH-5:0], 4'b1110};
                        end else begin
                            q_reg <= {q_reg[WIDTH-3:0], 2'b10};
                        end
                        bit_len_reg   <= bit_len_sum[CNT_W-1:0];
                        sym_count_reg <= sym_count_reg + CNT_W'(1);
                    end else if (want_push) begin
                        // No room for the symbol: keep the entry, remember the loss.
                        overflow_reg <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    correct_reg      <= (q_reg == target) && !overflow_reg &&
                                        (sym_count_reg != '0);
                    busy_reg         <= 1'b0;
                    result_valid_reg <= 1'b1;
                    state_reg        <= ST_DONE;
                end
                ST_DONE: begin
                    // Result held until clear; target changes are not re-scored.
                end
                default: begin
                    state_reg <= ST_ENTRY;
                end
            endcase
        end
    end

    assign q            = q_reg;
    assign bit_len      = bit_len_reg;
    assign sym_count    = sym_count_reg;
    assign overflow     = overflow_reg;
    assign busy         = busy_reg;
    assign result_valid = result_valid_reg;
    assign correct      = correct_reg;

endmodule

// File: tb/tb_morse_guess_buffer.sv
// Directed bench for morse_guess_buffer: expected snapshots are queued as each
// step is driven and popped/compared one cycle later against the DUT outputs.
module tb_morse_guess_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ld_dot = 1'b0, ld_line = 1'b0, backspace = 1'b0, finish = 1'b0, clear = 1'b0;
    logic [19:0] target = '0;

    logic [19:0] a_q,  b_q;
    logic [4:0]  a_bl, b_bl, a_sc, b_sc;
    logic        a_ov, a_busy, a_rv, a_corr;
    logic        b_ov, b_busy, b_rv, b_corr;

    typedef struct packed {
        logic [19:0] q;
        logic [4:0]  bl;
        logic [4:0]  sc;
        logic        ov;
        logic        busy;
        logic        rv;
        logic        corr;
    } snap_t;

    snap_t exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    passes = 0;

    always #5 clock = ~clock;

    morse_guess_buffer #(.WIDTH(20), .MAX_SYMBOLS(8), .CNT_W(5)) dut_a (
        .clock(clock), .reset(reset), .ld_dot(ld_dot), .ld_line(ld_line),
        .backspace(backspace), .finish(finish), .clear(clear), .target(target),
        .q(a_q), .bit_len(a_bl), .sym_count(a_sc), .overflow(a_ov),
        .busy(a_busy), .result_valid(a_rv), .correct(a_corr)
    );

    morse_guess_buffer #(.WIDTH(20), .MAX_SYMBOLS(3), .CNT_W(5)) dut_b (
        .clock(clock), .reset(reset), .ld_dot(ld_dot), .ld_line(ld_line),
        .backspace(backspace), .finish(finish), .clear(clear), .target(target),
        .q(b_q), .bit_len(b_bl), .sym_count(b_sc), .overflow(b_ov),
        .busy(b_busy), .result_valid(b_rv), .correct(b_corr)
    );

    function automatic snap_t mk(input logic [19:0] q, input logic [4:0] bl, input logic [4:0] sc,
                                 input logic ov, input logic bz, input logic rv, input logic co);
        snap_t s;
        s.q = q; s.bl = bl; s.sc = sc; s.ov = ov; s.busy = bz; s.rv = rv; s.corr = co;
        return s;
    endfunction

    task automatic compare(input bit sel);
        snap_t e, o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = sel ? mk(b_q, b_bl, b_sc, b_ov, b_busy, b_rv, b_corr)
                : mk(a_q, a_bl, a_sc, a_ov, a_busy, a_rv, a_corr);
        checks++; assert (o.q === e.q) passes++;
            else $error("FAIL %s q got %h expected %h", t, o.q, e.q);
        checks++; assert (o.bl === e.bl) passes++;
            else $error("FAIL %s bit_len got %0d expected %0d", t, o.bl, e.bl);
        checks++; assert (o.sc === e.sc) passes++;
            else $error("FAIL %s sym_count got %0d expected %0d", t, o.sc, e.sc);
        checks++; assert (o.ov === e.ov) passes++;
            else $error("FAIL %s overflow got %b expected %b", t, o.ov, e.ov);
        checks++; assert (o.busy === e.busy) passes++;
            else $error("FAIL %s busy got %b expected %b", t, o.busy, e.busy);
        checks++; assert (o.rv === e.rv) passes++;
            else $error("FAIL %s result_valid got %b expected %b", t, o.rv, e.rv);
        checks++; assert (o.corr === e.corr) passes++;
            else $error("FAIL %s correct got %b expected %b", t, o.corr, e.corr);
        $display("step %-12s dut%s q=%h bit_len=%0d sym_count=%0d ov=%b busy=%b rv=%b correct=%b",
                 t, sel ? "B" : "A", o.q, o.bl, o.sc, o.ov, o.busy, o.rv, o.corr);
    endtask

    // Drive one cycle of inputs (r,d,l,b,f,c), queue the expectation, compare after the edge.
    task automatic step(input string tag, input bit sel,
                        input logic r, input logic d, input logic l,
                        input logic b, input logic f, input logic c, input snap_t e);
        @(negedge clock);
        reset = r; ld_dot = d; ld_line = l; backspace = b; finish = f; clear = c;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        reset = 0; ld_dot = 0; ld_line = 0; backspace = 0; finish = 0; clear = 0;
        compare(sel);
    endtask

    snap_t zero;

    initial begin
        zero = mk(20'h0, 5'd0, 5'd0, 0, 0, 0, 0);

        // 1: reset, dot, line, finish scored against 0x2E
        step("reset",     0, 1,0,0,0,0,0, zero);
        step("dot",       0, 0,1,0,0,0,0, mk(20'h00002, 2, 1, 0,0,0,0));
        step("line",      0, 0,0,1,0,0,0, mk(20'h0002E, 6, 2, 0,0,0,0));
        target = 20'h0002E;
        step("finish",    0, 0,0,0,0,1,0, mk(20'h0002E, 6, 2, 0,1,0,0));
        step("check",     0, 0,0,0,0,0,0, mk(20'h0002E, 6, 2, 0,0,1,1));
        target = 20'h00000;
        step("done_tgt",  0, 0,0,0,0,0,0, mk(20'h0002E, 6, 2, 0,0,1,1));
        step("clear",     0, 0,0,0,0,0,1, zero);

        // 2: backspace, including underflow attempts
        step("dot2",      0, 0,1,0,0,0,0, mk(20'h00002, 2, 1, 0,0,0,0));
        step("line2",     0, 0,0,1,0,0,0, mk(20'h0002E, 6, 2, 0,0,0,0));
        step("bksp1",     0, 0,0,0,1,0,0, mk(20'h00002, 2, 1, 0,0,0,0));
        step("bksp2",     0, 0,0,0,1,0,0, zero);
        step("bksp_empty",0, 0,0,0,1,0,0, zero);

        // 4a: dot and line together are ignored
        step("dot_line",  0, 0,1,1,0,0,0, zero);

        // 3: fill to WIDTH, overflow, score with overflow set
        step("line_a",    0, 0,0,1,0,0,0, mk(20'h0000E,  4, 1, 0,0,0,0));
        step("line_b",    0, 0,0,1,0,0,0, mk(20'h000EE,  8, 2, 0,0,0,0));
        step("line_c",    0, 0,0,1,0,0,0, mk(20'h00EEE, 12, 3, 0,0,0,0));
        step("line_d",    0, 0,0,1,0,0,0, mk(20'h0EEEE, 16, 4, 0,0,0,0));
        step("line_e",    0, 0,0,1,0,0,0, mk(20'hEEEEE, 20, 5, 0,0,0,0));
        step("dot_full",  0, 0,1,0,0,0,0, mk(20'hEEEEE, 20, 5, 1,0,0,0));
        step("bksp_ov",   0, 0,0,0,1,0,0, mk(20'h0EEEE, 16, 4, 1,0,0,0));
        step("line_f",    0, 0,0,1,0,0,0, mk(20'hEEEEE, 20, 5, 1,0,0,0));
        target = 20'hEEEEE;
        step("finish_ov", 0, 0,0,0,0,1,0, mk(20'hEEEEE, 20, 5, 1,1,0,0));
        step("check_ov",  0, 0,0,0,0,0,0, mk(20'hEEEEE, 20, 5, 1,0,1,0));

        // 4b: inputs ignored in DONE, clear returns to ENTRY
        step("done_dot",  0, 0,1,0,0,0,0, mk(20'hEEEEE, 20, 5, 1,0,1,0));
        step("done_bksp", 0, 0,0,0,1,0,0, mk(20'hEEEEE, 20, 5, 1,0,1,0));
        step("clear2",    0, 0,0,0,0,0,1, zero);

        // empty guess: sequence runs, correct stays 0 even though q == target
        target = 20'h00000;
        step("fin_empty", 0, 0,0,0,0,1,0, mk(20'h0, 0, 0, 0,1,0,0));
        step("chk_empty", 0, 0,0,0,0,0,0, mk(20'h0, 0, 0, 0,0,1,0));
        step("clear3",    0, 0,0,0,0,0,1, zero);

        // 5: reset during CHECK, then normal entry
        step("dot5",      0, 0,1,0,0,0,0, mk(20'h00002, 2, 1, 0,0,0,0));
        step("finish5",   0, 0,0,0,0,1,0, mk(20'h00002, 2, 1, 0,1,0,0));
        step("rst_check", 0, 1,0,0,0,0,0, zero);
        step("dot5b",     0, 0,1,0,0,0,0, mk(20'h00002, 2, 1, 0,0,0,0));

        // clear during CHECK, and input priority in ENTRY
        step("finish6",   0, 0,0,0,0,1,0, mk(20'h00002, 2, 1, 0,1,0,0));
        step("clr_check", 0, 0,0,0,0,0,1, zero);
        step("dot6",      0, 0,1,0,0,0,0, mk(20'h00002, 2, 1, 0,0,0,0));
        step("bksp_dot",  0, 0,1,0,1,0,0, zero);
        step("dot7",      0, 0,1,0,0,0,0, mk(20'h00002, 2, 1, 0,0,0,0));
        target = 20'h00002;
        step("fin_dot",   0, 0,1,0,0,1,0, mk(20'h00002, 2, 1, 0,1,0,0));
        step("chk_dot",   0, 0,0,0,0,0,0, mk(20'h00002, 2, 1, 0,0,1,1));
        step("clr_fin",   0, 0,0,0,1,1,1, zero);

        // 6: MAX_SYMBOLS=3 instance, symbol-count limit
        step("b_reset",   1, 1,0,0,0,0,0, zero);
        step("b_dot1",    1, 0,1,0,0,0,0, mk(20'h00002, 2, 1, 0,0,0,0));
        step("b_dot2",    1, 0,1,0,0,0,0, mk(20'h0000A, 4, 2, 0,0,0,0));
        step("b_dot3",    1, 0,1,0,0,0,0, mk(20'h0002A, 6, 3, 0,0,0,0));
        step("b_dot4",    1, 0,1,0,0,0,0, mk(20'h0002A, 6, 3, 1,0,0,0));
        step("b_bksp",    1, 0,0,0,1,0,0, mk(20'h0000A, 4, 2, 1,0,0,0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
